irq_aggregator: RTL

Parametrised interrupt aggregator between the FPGC interrupt sources (OS timers, UART rx, PS/2, SPI interrupt lines, GPU frameDrawn) and the CPU's single interrupt input. Synchronises raw sources, detects edge or level per channel, latches pending state, applies a mask and presents the highest-priority active channel to the CPU through a request/acknowledge handshake. Replaces the fixed int1..int4/ext_int1..ext_int4 wiring with a CHANNELS-wide vector.

---
 rtl/irq_aggregator.sv | 117 +++++++++++
 1 files changed

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: per-channel synchroniser, edge/level pending latch, mask, fixed priority,
// req/ack handshake to a single CPU interrupt. Optional lost-edge flags enabled by IRQ_AGG_OVERFLOW_EN.
module irq_aggregator #(
   parameter int CHANNELS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        nreset,
   input  logic [CHANNELS-1:0]         irq_in,
   input  logic [CHANNELS-1:0]         edge_sel,
   input  logic [CHANNELS-1:0]         mask,
   input  logic [CHANNELS-1:0]         clr,
   input  logic                        irq_ack,
   output logic                        cpu_irq,
   output logic [$clog2(CHANNELS)-1:0] irq_id,
   output logic [CHANNELS-1:0]         pending,
   output logic [CHANNELS-1:0]         overflow
);
   localparam int ID_W = $clog2(CHANNELS);

   typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;
   state_t state, state_next;

   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0] synced, prev, edge_det, active;
   logic [CHANNELS-1:0] id_onehot, ack_clr, pending_next;
   logic [ID_W-1:0]     prio_id, id_next;
   logic                prio_found, cpu_irq_next, ack_take;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         prev <= '0;
      end else begin
         sync_q[0] <= irq_in;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         prev <= synced;
      end
   end

   assign synced    = sync_q[SYNC_STAGES-1];
   assign edge_det  = synced & ~prev;
   assign active    = pending & mask;
   assign id_onehot = CHANNELS'(1) << irq_id;
   assign ack_clr   = ack_take ? id_onehot : '0;

   // Edge channels: set beats clear. Level channels simply track the synchronised input.
   assign pending_next = (edge_sel & (edge_det | (pending & ~(clr | ack_clr))))
                       | (~edge_sel & synced);

   always_ff @(posedge clk) begin
      if (!nreset) pending <= '0;
      else         pending <= pending_next;
   end

`ifdef IRQ_AGG_OVERFLOW_EN
   always_ff @(posedge clk) begin
      if (!nreset) overflow <= '0;
      else         overflow <= (edge_sel & edge_det & pending) | (overflow & ~clr);
   end
`else
   assign overflow = '0;
`endif

   always_comb begin
      prio_id    = '0;
      prio_found = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (active[i] && !prio_found) begin
            prio_id    = ID_W'(i);
            prio_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_next   = state;
      cpu_irq_next = 1'b0;
      id_next      = irq_id;
      ack_take     = 1'b0;
      case (state)
         IDLE: begin
            if (prio_found) begin
               state_next   = ASSERT;
               cpu_irq_next = 1'b1;
               id_next      = prio_id;
            end
         end
         ASSERT: begin
            // Ack outranks withdrawal of the latched channel.
            if (irq_ack) begin
               state_next = HOLDOFF;
               ack_take   = 1'b1;
            end else if ((active & id_onehot) == '0) begin
               state_next = IDLE;
            end else begin
               cpu_irq_next = 1'b1;
            end
         end
         HOLDOFF: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state   <= IDLE;
         cpu_irq <= 1'b0;
         irq_id  <= '0;
      end else begin
         state   <= state_next;
         cpu_irq <= cpu_irq_next;
         irq_id  <= id_next;
      end
   end

endmodule
